mem_responder: RTL and testbench

Memory-side responder for the multi-cycle CPU controller: services instruction fetches (port 1) and LDR/STR data accesses (port 2) against one single-ported word array. Replaces fixed controller stall states with a strobe/valid handshake, a programmable access latency and fixed-priority arbitration. Sits between the controller/datapath and the storage array.

---
 rtl/mem_resp_pkg.sv | 25 ++
 rtl/mem_resp_array.sv | 32 +++
 rtl/mem_responder.sv | 211 +++++++++++++++++++++
 tb/tb_mem_responder.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and defaults for the memory responder.
// State and port-id enums, default parameters, index-width helper.
package mem_resp_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 11;
    localparam int DEF_DEPTH   = 2048;
    localparam int DEF_LATENCY = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } port_t;

    // Bits needed to index n items (never less than one bit).
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Single-port synchronous word RAM, one access per enabled edge.
// Ports: clk, en, we, addr, wdata in; rdata out (updated on enabled reads only).
module mem_resp_array
    import mem_resp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AW     = idx_w(DEF_DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // rdata holds its value across writes and idle cycles, so the
    // responder can read it for the whole response window.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: fetch port 1 and load/store port 2 share one word RAM.
// Per-port one-deep pending latches, port 2 priority, LATENCY-cycle responses.
// Ports: clk, rst (sync, active high); req1/addr1 -> valid1/rd_data1;
//        req2/w_en2/addr2/w_data2 -> valid2/rd_data2; busy; err.
// Option: MEM_RESP_RANGE_CHECK_EN enables the sticky out-of-range err flag;
//         without it addresses wrap modulo DEPTH and err is tied low.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              valid1,
    output logic [DATA_W-1:0] rd_data1,
    input  logic              req2,
    input  logic              w_en2,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [DATA_W-1:0] w_data2,
    output logic              valid2,
    output logic [DATA_W-1:0] rd_data2,
    output logic              busy,
    output logic              err
);

    localparam int AW = idx_w(DEPTH);
    localparam int CW = idx_w(LATENCY);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    state_t state, state_nx;
    logic [CW-1:0] cnt;

    logic              pend1, pend2, pw2;
    logic [ADDR_W-1:0] pa1, pa2;
    logic [DATA_W-1:0] pd2;

    logic              has1, has2;
    logic [ADDR_W-1:0] a1_eff, a2_eff;
    logic              w2_eff;
    logic [DATA_W-1:0] d2_eff;

    logic              ready, grant1, grant2, accept;
    port_t             acc_port;
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_we;
    logic              oob;
    logic [AW-1:0]     idx;

    port_t             cur_port, fin_port;
    logic              cur_we, cur_oob, fin_we, fin_oob;
    logic              done;

    logic [DATA_W-1:0] ram_rdata, src, hold1, hold2;
    logic              rv2, resp_oob;

    // A live strobe is served in its own cycle when no latch is pending.
    assign has1   = pend1 | req1;
    assign has2   = pend2 | req2;
    assign a1_eff = pend1 ? pa1 : addr1;
    assign a2_eff = pend2 ? pa2 : addr2;
    assign w2_eff = pend2 ? pw2 : w_en2;
    assign d2_eff = pend2 ? pd2 : w_data2;

    assign ready    = (state == IDLE);
    assign grant2   = ready & has2;
    assign grant1   = ready & has1 & ~has2;
    assign accept   = grant1 | grant2;
    assign acc_port = grant2 ? PORT_DATA : PORT_FETCH;
    assign acc_addr = grant2 ? a2_eff : a1_eff;
    assign acc_we   = grant2 & w2_eff;

`ifdef MEM_RESP_RANGE_CHECK_EN
    logic err_q;

    assign oob = (32'(acc_addr) >= DEPTH);
    assign idx = AW'(acc_addr);
    assign err = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept && oob) begin
            err_q <= 1'b1;
        end
    end
`else
    assign oob = 1'b0;
    assign idx = AW'(32'(acc_addr) % DEPTH);
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pend1 <= 1'b0;
            pend2 <= 1'b0;
        end else begin
            if (grant1) begin
                pend1 <= 1'b0;
            end else if (req1 && !pend1) begin
                pend1 <= 1'b1;
            end
            if (grant2) begin
                pend2 <= 1'b0;
            end else if (req2 && !pend2) begin
                pend2 <= 1'b1;
            end
        end
    end

    // Captured fields are only meaningful while the pending bit is set.
    always_ff @(posedge clk) begin
        if (req1 && !pend1) begin
            pa1 <= addr1;
        end
        if (req2 && !pend2) begin
            pa2 <= addr2;
            pw2 <= w_en2;
            pd2 <= w_data2;
        end
    end

    mem_resp_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_array (
        .clk   (clk),
        .en    (accept & ~oob),
        .we    (acc_we),
        .addr  (idx),
        .wdata (d2_eff),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept && LATENCY > 1) state_nx = BUSY;
            BUSY: if (cnt == CW'(1)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == BUSY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CNT_LOAD;
        end else if (state == BUSY) begin
            cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cur_port <= acc_port;
            cur_we   <= acc_we;
            cur_oob  <= oob;
        end
    end

    // With LATENCY 1 the response is due at the acceptance edge itself.
    assign fin_port = (LATENCY == 1) ? acc_port : cur_port;
    assign fin_we   = (LATENCY == 1) ? acc_we : cur_we;
    assign fin_oob  = (LATENCY == 1) ? oob : cur_oob;
    assign done     = (state == BUSY && cnt == CW'(1)) ||
                      (accept && LATENCY == 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid1   <= 1'b0;
            valid2   <= 1'b0;
            rv2      <= 1'b0;
            resp_oob <= 1'b0;
            hold1    <= '0;
            hold2    <= '0;
        end else begin
            valid1   <= done && (fin_port == PORT_FETCH);
            valid2   <= done && (fin_port == PORT_DATA);
            rv2      <= done && (fin_port == PORT_DATA) && !fin_we;
            resp_oob <= fin_oob;
            if (valid1) hold1 <= src;
            if (rv2)    hold2 <= src;
        end
    end

    // RAM output stays stable until the next acceptance, which can only
    // happen at the end of the response cycle, so it is shown directly
    // during the valid pulse and latched into the hold register after it.
    assign src      = resp_oob ? '0 : ram_rdata;
    assign rd_data1 = valid1 ? src : hold1;
    assign rd_data2 = rv2 ? src : hold2;

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: directed scenarios plus a randomized
// stream checked against a transaction-level model.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req1 = 1'b0, req2 = 1'b0, w_en2 = 1'b0;
    logic [10:0] addr1 = '0, addr2 = '0;
    logic [31:0] w_data2 = '0;
    logic        valid1, valid2, busy, err;
    logic [31:0] rd_data1, rd_data2;

    logic        b_rst = 1'b1;
    logic        b_req1 = 1'b0, b_req2 = 1'b0, b_w_en2 = 1'b0;
    logic [10:0] b_addr1 = '0, b_addr2 = '0;
    logic [31:0] b_w_data2 = '0;
    logic        b_valid1, b_valid2, b_busy, b_err;
    logic [31:0] b_rd_data1, b_rd_data2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_responder #(
        .DATA_W(32), .ADDR_W(11), .DEPTH(2048), .LATENCY(2)
    ) dut (
        .clk(clk), .rst(rst),
        .req1(req1), .addr1(addr1), .valid1(valid1), .rd_data1(rd_data1),
        .req2(req2), .w_en2(w_en2), .addr2(addr2), .w_data2(w_data2),
        .valid2(valid2), .rd_data2(rd_data2), .busy(busy), .err(err)
    );

    mem_responder #(
        .DATA_W(32), .ADDR_W(11), .DEPTH(1024), .LATENCY(1)
    ) dut_b (
        .clk(clk), .rst(b_rst),
        .req1(b_req1), .addr1(b_addr1), .valid1(b_valid1), .rd_data1(b_rd_data1),
        .req2(b_req2), .w_en2(b_w_en2), .addr2(b_addr2), .w_data2(b_w_data2),
        .valid2(b_valid2), .rd_data2(b_rd_data2), .busy(b_busy), .err(b_err)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_a(input logic [10:0] a, input logic [31:0] d);
        next_cycle();
        req2 = 1'b1; w_en2 = 1'b1; addr2 = a; w_data2 = d;
        next_cycle();
        req2 = 1'b0; w_en2 = 1'b0;
        next_cycle();
    endtask

    task automatic wr_b(input logic [10:0] a, input logic [31:0] d);
        next_cycle();
        b_req2 = 1'b1; b_w_en2 = 1'b1; b_addr2 = a; b_w_data2 = d;
        next_cycle();
        b_req2 = 1'b0; b_w_en2 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; b_rst = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if ({valid1, valid2, busy, err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctl got %b want 0000", {valid1, valid2, busy, err});
        end
        checks++;
        if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got %h/%h want 0/0", rd_data1, rd_data2);
        end
        checks++;
        if ({b_valid1, b_valid2, b_busy, b_err} !== 4'b0000 ||
            b_rd_data1 !== 32'h0 || b_rd_data2 !== 32'h0) begin
            errors++;
            $display("FAIL reset_b got %b %h %h want 0", {b_valid1, b_valid2, b_busy, b_err},
                     b_rd_data1, b_rd_data2);
        end
        next_cycle();
        rst = 1'b0; b_rst = 1'b0;
    endtask

    task automatic test_fetch();
        logic [2:0] want [7];
        want = '{3'b000, 3'b001, 3'b010, 3'b000, 3'b001, 3'b100, 3'b000};
        for (int k = 0; k < 7; k++) begin
            next_cycle();
            req1 = 1'b0; req2 = 1'b0; w_en2 = 1'b0;
            if (k == 0) begin
                req2 = 1'b1; w_en2 = 1'b1; addr2 = 11'h010; w_data2 = 32'hE3A01005;
            end
            if (k == 3) begin
                req1 = 1'b1; addr1 = 11'h010;
            end
            @(negedge clk);
            checks++;
            if ({valid1, valid2, busy} !== want[k]) begin
                errors++;
                $display("FAIL fetch_ctl k=%0d got %b want %b", k, {valid1, valid2, busy}, want[k]);
            end
            if (k == 2) begin
                checks++;
                if (rd_data2 !== 32'h0) begin
                    errors++;
                    $display("FAIL fetch_wack_rd2 got %h want 0", rd_data2);
                end
            end
            if (k >= 5) begin
                checks++;
                if (rd_data1 !== 32'hE3A01005) begin
                    errors++;
                    $display("FAIL fetch_rd1 k=%0d got %h want e3a01005", k, rd_data1);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [2:0] want;
        wr_a(11'h004, 32'hA5A50004);
        wr_a(11'h008, 32'h5A5A0008);
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            req1 = (k == 0); addr1 = 11'h004;
            req2 = (k == 0); w_en2 = 1'b0; addr2 = 11'h008;
            @(negedge clk);
            want = (k == 2) ? 3'b010 : (k == 4) ? 3'b100 :
                   (k == 1 || k == 3) ? 3'b001 : 3'b000;
            checks++;
            if ({valid1, valid2, busy} !== want) begin
                errors++;
                $display("FAIL simul_ctl k=%0d got %b want %b", k, {valid1, valid2, busy}, want);
            end
            if (k == 2) begin
                checks++;
                if (rd_data2 !== 32'h5A5A0008) begin
                    errors++;
                    $display("FAIL simul_rd2 got %h want 5a5a0008", rd_data2);
                end
            end
            if (k == 4) begin
                checks++;
                if (rd_data1 !== 32'hA5A50004) begin
                    errors++;
                    $display("FAIL simul_rd1 got %h want a5a50004", rd_data1);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] want [5];
        want = '{3'b000, 3'b001, 3'b010, 3'b001, 3'b010};
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            req2 = (k < 2); w_en2 = (k == 0); addr2 = 11'h100;
            w_data2 = (k == 0) ? 32'hDEADBEEF : 32'h0;
            @(negedge clk);
            checks++;
            if ({valid1, valid2, busy} !== want[k]) begin
                errors++;
                $display("FAIL b2b_ctl k=%0d got %b want %b", k, {valid1, valid2, busy}, want[k]);
            end
            if (k == 2) begin
                checks++;
                if (rd_data2 !== 32'h5A5A0008) begin
                    errors++;
                    $display("FAIL b2b_wack_rd2 got %h want 5a5a0008", rd_data2);
                end
            end
            if (k == 4) begin
                checks++;
                if (rd_data2 !== 32'hDEADBEEF) begin
                    errors++;
                    $display("FAIL b2b_rd2 got %h want deadbeef", rd_data2);
                end
            end
        end
        req2 = 1'b0;
    endtask

    task automatic test_reset_mid();
        next_cycle();
        req2 = 1'b1; w_en2 = 1'b0; addr2 = 11'h100;
        next_cycle();
        req2 = 1'b0; rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_busy got %b want 1", busy);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({valid1, valid2, busy} !== 3'b000 || rd_data1 !== 32'h0 || rd_data2 !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_out got %b %h %h want 000 0 0", {valid1, valid2, busy},
                     rd_data1, rd_data2);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({valid1, valid2, busy} !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_late got %b want 000", {valid1, valid2, busy});
        end
        next_cycle();
        req2 = 1'b1; w_en2 = 1'b1; addr2 = 11'h020; w_data2 = 32'hCAFEF00D;
        next_cycle();
        req2 = 1'b0; w_en2 = 1'b0; rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        next_cycle();
        req1 = 1'b1; addr1 = 11'h020;
        next_cycle();
        req1 = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++;
        if ({valid1, valid2, busy} !== 3'b100 || rd_data1 !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL rstmid_commit got %b %h want 100 cafef00d", {valid1, valid2, busy},
                     rd_data1);
        end
    endtask

    task automatic test_latency1();
        logic [31:0] vals [8];
        for (int i = 0; i < 8; i++) begin
            vals[i] = $urandom;
            wr_b(11'h020 + 11'(i), vals[i]);
        end
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            b_req1 = 1'b1; b_addr1 = 11'h020 + 11'(i);
            @(negedge clk);
            checks++;
            if ({b_valid1, b_busy} !== 2'b00) begin
                errors++;
                $display("FAIL lat1_acc i=%0d got %b want 00", i, {b_valid1, b_busy});
            end
            next_cycle();
            b_req1 = 1'b0;
            @(negedge clk);
            checks++;
            if ({b_valid1, b_valid2, b_busy} !== 3'b100 || b_rd_data1 !== vals[i]) begin
                errors++;
                $display("FAIL lat1_rsp i=%0d got %b %h want 100 %h", i,
                         {b_valid1, b_valid2, b_busy}, b_rd_data1, vals[i]);
            end
        end
    endtask

    task automatic test_range();
        logic [31:0] want_rd;
        logic        want_err;
`ifdef MEM_RESP_RANGE_CHECK_EN
        want_rd = 32'h0; want_err = 1'b1;
`else
        want_rd = 32'h12345678; want_err = 1'b0;
`endif
        wr_b(11'h000, 32'h12345678);
        next_cycle();
        b_req2 = 1'b1; b_w_en2 = 1'b0; b_addr2 = 11'h400;
        next_cycle();
        b_req2 = 1'b0;
        @(negedge clk);
        checks++;
        if (b_valid2 !== 1'b1 || b_rd_data2 !== want_rd || b_err !== want_err) begin
            errors++;
            $display("FAIL range_rsp got v=%b d=%h e=%b want 1 %h %b", b_valid2, b_rd_data2,
                     b_err, want_rd, want_err);
        end
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if (b_valid2 !== 1'b0 || b_err !== want_err || b_rd_data2 !== want_rd) begin
            errors++;
            $display("FAIL range_sticky got v=%b d=%h e=%b want 0 %h %b", b_valid2,
                     b_rd_data2, b_err, want_rd, want_err);
        end
    endtask

    task automatic test_random();
        localparam int LAT = 2;
        logic [31:0] mdl [16];
        bit          s_on, s_p2, s_wr, p1, p2, pw, r1, r2, w, ev1, ev2, eb;
        int          s_t, pa1, pa2, a1, a2;
        logic [31:0] s_dat, pd, d, exp1, exp2;
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mdl[i] = $urandom;
            wr_a(11'h200 + 11'(i), mdl[i]);
        end
        s_on = 0; p1 = 0; p2 = 0; exp1 = '0; exp2 = '0;
        s_t = 0; s_p2 = 0; s_wr = 0; s_dat = '0; pa1 = 0; pa2 = 0; pw = 0; pd = '0;
        for (int c = 0; c < 400; c++) begin
            next_cycle();
            r1 = ($urandom_range(0, 2) == 0);
            r2 = ($urandom_range(0, 2) == 0);
            w  = $urandom_range(0, 1);
            a1 = $urandom_range(0, 15);
            a2 = $urandom_range(0, 15);
            d  = $urandom;
            req1 = r1; addr1 = 11'h200 + 11'(a1);
            req2 = r2; w_en2 = w; addr2 = 11'h200 + 11'(a2); w_data2 = d;
            ev1 = 0; ev2 = 0; eb = 0;
            if (s_on) begin
                if (c == s_t) begin
                    s_on = 0;
                    if (s_p2) begin
                        ev2 = 1;
                        if (!s_wr) exp2 = s_dat;
                    end else begin
                        ev1 = 1;
                        exp1 = s_dat;
                    end
                end else begin
                    eb = 1;
                end
            end
            if (r1 && !p1) begin p1 = 1; pa1 = a1; end
            if (r2 && !p2) begin p2 = 1; pa2 = a2; pw = w; pd = d; end
            if (!s_on && (p1 || p2)) begin
                s_on = 1;
                s_t = c + LAT;
                if (p2) begin
                    p2 = 0; s_p2 = 1; s_wr = pw;
                    if (pw) mdl[pa2] = pd;
                    s_dat = mdl[pa2];
                end else begin
                    p1 = 0; s_p2 = 0; s_wr = 0;
                    s_dat = mdl[pa1];
                end
            end
            @(negedge clk);
            checks++;
            if ({valid1, valid2, busy} !== {ev1, ev2, eb}) begin
                errors++;
                $display("FAIL rand_ctl c=%0d got %b want %b", c, {valid1, valid2, busy},
                         {ev1, ev2, eb});
            end
            checks++;
            if (rd_data1 !== exp1) begin
                errors++;
                $display("FAIL rand_rd1 c=%0d got %h want %h", c, rd_data1, exp1);
            end
            checks++;
            if (rd_data2 !== exp2) begin
                errors++;
                $display("FAIL rand_rd2 c=%0d got %h want %h", c, rd_data2, exp2);
            end
        end
        next_cycle();
        req1 = 1'b0; req2 = 1'b0; w_en2 = 1'b0;
        repeat (6) next_cycle();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        test_latency1();
        test_range();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
